reduce_sync_mem: RTL
====================

// Module: reduce_sync_mem
// PURPOSE
//  Programmable reduction engine over a synchronous-read, single-clock memory.
//  - On start, reads `size` words beginning at `base`, at one word per cycle, with the address wrapping modulo DEPTH.
//  - Folds the words with the selected operator (SUM/MAX/MIN/XOR) and presents the result with a done flag.
//  - Successor to the fixed sum-over-memory block: adds base offset, operator select, start/busy/done handshake and a host write port.
// PARAMETERS
//  AWIDTH             10    address width; must satisfy 2**AWIDTH >= DEPTH
//  DWIDTH             32    data and result width
//  DEPTH              1024  number of memory words
//  MEM_INIT_HEX_FILE  ""    $readmemh init file; empty string = no init
// PORTS
//  clk      in   1       sole clock; everything is on posedge
//  reset    in   1       synchronous, active-high
//  start    in   1       request a reduction; accepted only when busy=0
//  base     in   AWIDTH  first address; latched on accept
//  size     in   32      number of words to fold; latched on accept
//  mode     in   2       0=SUM 1=MAX(unsigned) 2=MIN(unsigned) 3=XOR; latched on accept
//  wr_en    in   1       host write strobe
//  wr_addr  in   AWIDTH  host write address
//  wr_data  in   DWIDTH  host write data
//  busy     out  1       reduction in progress (states READ, DRAIN)
//  done     out  1       result valid; held until the next accepted start or reset
//  result   out  DWIDTH  reduction result; stable while done=1
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, result=0, internal counters=0. Memory contents are kept.
//  - Reset mid-run aborts the run: IDLE on the next edge, no done pulse.
//  - FSM states: IDLE, READ, DRAIN, DONE.
//    - IDLE/DONE --start--> READ: latches base/size/mode, loads the accumulator with the operator identity, clears done.
//    - READ issues one address per cycle: base, base+1, ...; the address is (base+i) mod DEPTH.
//    - After the last address is issued, READ -> DRAIN.
//    - DRAIN folds the remaining in-flight data, then -> DONE.
//  - Operator identities: SUM 0, MAX 0, MIN all-ones, XOR 0.
//  - Memory read latency is exactly 1 cycle. The pipeline folds one word per cycle with no bubbles.
//  - Latency: let E0 be the edge that accepts start. The first cycle with done=1 follows edge E0+size+2.
//  - size=0: READ is skipped, DONE at E0+1, result = identity of the selected mode.
//  - size > DEPTH: the address wraps and words are re-read and re-folded, so SUM counts them again.
//  - SUM wraps modulo 2**DWIDTH unless REDUCE_SATURATE_EN is defined.
//  - start while busy=1 is ignored. start in DONE restarts and done drops on the accept edge.
//  - Writes:
//    - Accepted only while busy=0; dropped while busy=1.
//    - A write on the same edge as start is accepted and is visible to the run.
//    - The written word is readable from the next cycle.
//  - mode, base and size changing during a run have no effect on that run.
// CONFIGURATION
//  REDUCE_SATURATE_EN
//   - defined: SUM clamps at 2**DWIDTH-1; once saturated it stays there for the rest of the run.
//   - undefined: SUM wraps modulo 2**DWIDTH.
//   - MAX/MIN/XOR are unaffected either way.
// TESTING
//  1. Init from sync_mem_init_hex.mif; SUM base=0 size=1024 -> result=541587138, done 1026 cycles after the accept edge.
//  2. Write 5,9,3 at addrs 1022,1023,0; MAX base=1022 size=3 -> 9; MIN -> 3; XOR -> 15 (address wrap checked).
//  3. SUM size=0 -> done at E0+1, result=0. MIN size=0 -> result=0xFFFFFFFF.
//  4. Start a run, pulse start and wr_en mid-run, then assert reset at cycle 100:
//     - extra start ignored and write dropped;
//     - reset -> busy=0, done=0, result=0 next cycle, no done pulse;
//     - a following run produces the correct result.
//  5. Write 0xFFFFFFFF at addrs 0 and 1; SUM base=0 size=2 -> 0xFFFFFFFE, or 0xFFFFFFFF with REDUCE_SATURATE_EN.
//  6. Two back-to-back runs, the second started while done=1 -> done drops on the accept edge and the new result is correct.

Source files
------------

// File: rtl/reduce_sync_mem.sv
// rtl/reduce_sync_mem.sv - SUM/MAX/MIN/XOR reduction over a sync-read memory with a host write port.
// Optional: define REDUCE_SATURATE_EN to make SUM clamp at all-ones instead of wrapping.
module reduce_sync_mem #(
    parameter int    AWIDTH            = 10,
    parameter int    DWIDTH            = 32,
    parameter int    DEPTH             = 1024,
    parameter string MEM_INIT_HEX_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AWIDTH-1:0] base,
    input  logic [31:0]       size,
    input  logic [1:0]        mode,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [DWIDTH-1:0] result
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [1:0] MODE_SUM = 2'd0;
    localparam logic [1:0] MODE_MAX = 2'd1;
    localparam logic [1:0] MODE_MIN = 2'd2;

    state_t            state;
    logic [AWIDTH-1:0] addr_q;
    logic [31:0]       remaining;
    logic [1:0]        mode_q;
    logic [DWIDTH-1:0] acc;
    logic [DWIDTH-1:0] rd_data;
    logic              rd_valid;
    logic [DWIDTH-1:0] mem [DEPTH];

    function automatic logic [DWIDTH-1:0] identity(input logic [1:0] m);
        return (m == MODE_MIN) ? {DWIDTH{1'b1}} : {DWIDTH{1'b0}};
    endfunction

    function automatic logic [DWIDTH-1:0] fold(input logic [DWIDTH-1:0] a,
                                               input logic [DWIDTH-1:0] d,
                                               input logic [1:0]        m);
        logic [DWIDTH-1:0] r;
        case (m)
            MODE_SUM: begin
`ifdef REDUCE_SATURATE_EN
                logic [DWIDTH:0] s;
                s = {1'b0, a} + {1'b0, d};
                r = s[DWIDTH] ? {DWIDTH{1'b1}} : s[DWIDTH-1:0];
`else
                r = a + d;
`endif
            end
            MODE_MAX: r = (d > a) ? d : a;
            MODE_MIN: r = (d < a) ? d : a;
            default:  r = a ^ d;
        endcase
        return r;
    endfunction

    // Host writes are locked out for the whole run so the fold sees a stable image.
    always_ff @(posedge clk) begin
        if (wr_en && !busy)
            mem[wr_addr] <= wr_data;
        if (state == READ)
            rd_data <= mem[addr_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            acc       <= '0;
            addr_q    <= '0;
            remaining <= '0;
            mode_q    <= 2'd0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= (state == READ);
            if (rd_valid)
                acc <= fold(acc, rd_data, mode_q);

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        addr_q    <= base;
                        remaining <= size;
                        mode_q    <= mode;
                        acc       <= identity(mode);
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        // An empty run still passes through DRAIN so done lands one edge later.
                        state     <= (size == 32'd0) ? DRAIN : READ;
                    end
                end
                READ: begin
                    addr_q    <= (addr_q == AWIDTH'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
                    remaining <= remaining - 32'd1;
                    if (remaining == 32'd1)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (!rd_valid) begin
                        result <= acc;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
